unit_dispatch_seq: RTL
======================

# unit_dispatch_seq

Instruction dispatch sequencer between the decode stage and the five functional units (ALU, STACK, JMP, DMA, SCHED). It accepts one decoded instruction type per valid/ready handshake and issues a one-cycle start pulse to the selected unit. It then holds further issue until that unit reports done, a timeout expires, or a flush aborts. It serialises unit usage and flags illegal types.

## Interface
- `TIMEOUT_CYCLES`, default 255: number of WAIT cycles before abort. A value of 0 disables the timeout.
- `CNT_W`, default 8: wait-counter width. `TIMEOUT_CYCLES` must be ≤ 2^CNT_W − 1.
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `ID_valid`  in  1  decoded instruction present
- `ID_ready`  out  1  dispatcher can accept
- `ID_type`  in  3  instruction class. Encodings:
  - 001 STACK
  - 010 / 011 ALU
  - 100 DMA
  - 101 SCHED
  - 111 JMP
  - 000 and 110 are illegal.
- `FLUSH`  in  1  abort current instruction, return to IDLE
- `UNIT_DONE`  in  5  completion level/pulse per unit, bit order [4:0] = {SCHED, DMA, JMP, STACK, ALU}
- `UNIT_START`  out  5  one-cycle start pulse, same bit order, at most one bit set
- `ACTIVE_UNIT`  out  5  one-hot of the owning unit, held in ISSUE and WAIT, otherwise 0
- `BUSY`  out  1  state ≠ IDLE
- `COMPLETE`  out  1  one-cycle pulse, the instruction finished with done
- `ILLEGAL`  out  1  one-cycle pulse, an illegal type was accepted
- `TIMEOUT`  out  1  one-cycle pulse, a WAIT timed out

## Operation
- **States:** IDLE, ISSUE, WAIT.
- **Ready:** `ID_ready = rst_n && state==IDLE && !FLUSH` (combinational).
- **Accept:** accept occurs at an edge with `ID_valid && ID_ready`.
  - Legal type: latch the one-hot unit into `ACTIVE_UNIT` and go to ISSUE.
  - Illegal type: stay in IDLE and register `ILLEGAL=1` for the next cycle. No start is issued.
- **ISSUE:** lasts exactly one cycle.
  - `UNIT_START = ACTIVE_UNIT` during this cycle.
  - The wait counter is cleared.
  - `UNIT_DONE` is ignored in this cycle.
  - Next state is WAIT.
- **WAIT:** each cycle, sample `UNIT_DONE & ACTIVE_UNIT`.
  - Match: go to IDLE, register `COMPLETE=1`, and clear `ACTIVE_UNIT`.
  - No match, with `TIMEOUT_CYCLES≠0` and `counter == TIMEOUT_CYCLES−1`: go to IDLE, register `TIMEOUT=1`, and clear `ACTIVE_UNIT`.
  - Otherwise: increment the counter. The counter never wraps, because the compare fires first. With `TIMEOUT_CYCLES=0` the counter saturates at all-ones.
- **Foreign done:** done bits from units other than the active one are ignored in every state.
- **Done vs. timeout:** if done and timeout occur in the same cycle, done wins. `COMPLETE=1` and `TIMEOUT=0`.
- **FLUSH:** highest priority below reset.
  - In any state, the next state is IDLE, `ACTIVE_UNIT` is cleared, and the counter is cleared.
  - No COMPLETE, TIMEOUT or ILLEGAL pulse is generated.
  - FLUSH during ISSUE suppresses `UNIT_START`, because `UNIT_START` is gated by `!FLUSH`.
  - FLUSH in IDLE blocks accept.
- **Reset:** at an edge with `rst_n=0`:
  - state becomes IDLE;
  - `ACTIVE_UNIT`, counter, `COMPLETE`, `ILLEGAL` and `TIMEOUT` become 0.
  - While `rst_n=0`, `UNIT_START=0`, `BUSY=0` and `ID_ready=0`.
  - Reset mid-WAIT silently abandons the instruction.

## Timing
- Accept at the end of cycle N.
  - Legal type: ISSUE in cycle N+1 with `UNIT_START` high, and `BUSY` high from N+1.
  - Illegal type: `ILLEGAL` high in N+1, and `ID_ready` stays high.
- WAIT starts at cycle N+2.
- Done sampled at the end of cycle M in WAIT: IDLE in M+1, `COMPLETE` high in M+1, and `ID_ready` high in M+1 (back-to-back accept allowed in M+1).
- Minimum issue interval is 3 cycles: accept, ISSUE, WAIT with done.
- Timeout: `TIMEOUT` is high in the cycle after exactly `TIMEOUT_CYCLES` WAIT cycles without done.
- All outputs except `ID_ready` are registered or decoded directly from registered state. `UNIT_START` is additionally gated by `FLUSH`.

## Test plan
- Reset, then ALU dispatch, all at default parameters.
  - Hold `rst_n=0` for 2 cycles: all outputs are 0.
  - Release, then give `ID_valid=1` with `ID_type=010` in cycle 1: `UNIT_START=00001` in cycle 2, `ACTIVE_UNIT=00001` in cycles 2–3.
  - `UNIT_DONE=00001` in cycle 3: `COMPLETE=1` and `BUSY=0` in cycle 4.
- Type map: dispatch 001, 011, 100, 101 and 111 in turn.
  - Required `UNIT_START` values, in order: 00010, 00001, 01000, 10000, 00100.
  - Types 000 and 110 give `ILLEGAL=1` for one cycle, no `UNIT_START`, and `BUSY` stays 0.
- Foreign done and timeout, with `TIMEOUT_CYCLES=4`.
  - Dispatch DMA, then drive `UNIT_DONE=00001` throughout WAIT.
  - Required: exactly 4 WAIT cycles, then `TIMEOUT=1`, `COMPLETE=0`, and `ID_ready=1` in the same cycle.
- Done on the last wait cycle, with `TIMEOUT_CYCLES=4`.
  - Assert the matching done in the 4th WAIT cycle: `COMPLETE=1` and `TIMEOUT=0`.
- FLUSH.
  - Assert `FLUSH` in the ISSUE cycle of a JMP dispatch: `UNIT_START` stays 00000, IDLE on the next cycle, no pulses.
  - Assert `FLUSH` in IDLE with `ID_valid=1`: `ID_ready=0`, nothing accepted.
- Back-to-back and reset mid-WAIT.
  - Hold `ID_valid` high with a done one cycle after each start: a `UNIT_START` every 3 cycles.
  - Pull `rst_n` low during WAIT: next cycle `BUSY=0` and `ACTIVE_UNIT=0`, and no `COMPLETE` after release.

Source files
------------

// File: rtl/unit_dispatch_seq_if.sv
// Decode-to-dispatcher handshake: one decoded instruction class per valid/ready transfer.
interface unit_dispatch_seq_if;
  logic       ID_valid;
  logic       ID_ready;
  logic [2:0] ID_type;

  modport master (output ID_valid, output ID_type, input ID_ready);
  modport slave  (input ID_valid, input ID_type, output ID_ready);
endinterface

// File: rtl/unit_dispatch_seq.sv
// Dispatch sequencer: issues one start pulse per accepted instruction and holds
// further issue until the owning unit reports done, a timeout expires, or a flush.
module unit_dispatch_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  unit_dispatch_seq_if.slave  id_if,
  input  logic                FLUSH,
  input  logic [4:0]          UNIT_DONE,
  output logic [4:0]          UNIT_START,
  output logic [4:0]          ACTIVE_UNIT,
  output logic                BUSY,
  output logic                COMPLETE,
  output logic                ILLEGAL,
  output logic                TIMEOUT
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [4:0]       type_onehot;
  logic             accept;
  logic             done_hit;
  logic             timeout_hit;

  // Unit bit order is {SCHED, DMA, JMP, STACK, ALU}; zero marks an illegal class.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    type_onehot = '0;
    case (id_if.ID_type)
      3'b001:         type_onehot = 5'b00010;
      3'b010, 3'b011: type_onehot = 5'b00001;
      3'b100:         type_onehot = 5'b01000;
      3'b101:         type_onehot = 5'b10000;
      3'b111:         type_onehot = 5'b00100;
      default:        type_onehot = '0;
    endcase
  end

  assign id_if.ID_ready = rst_n && (state == S_IDLE) && !FLUSH;
  assign accept         = id_if.ID_valid && id_if.ID_ready;
  assign done_hit       = |(UNIT_DONE & ACTIVE_UNIT);
  assign timeout_hit    = TO_EN && (wait_cnt == CNT_LAST);

  // Start and busy are forced low while reset is held, before the state register settles.
  assign UNIT_START = (rst_n && !FLUSH && state == S_ISSUE) ? ACTIVE_UNIT : 5'b00000;
  assign BUSY       = rst_n && (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ACTIVE_UNIT <= '0;
      wait_cnt    <= '0;
      COMPLETE    <= 1'b0;
      ILLEGAL     <= 1'b0;
      TIMEOUT     <= 1'b0;
    end else begin
      COMPLETE <= 1'b0;
      ILLEGAL  <= 1'b0;
      TIMEOUT  <= 1'b0;
      if (FLUSH) begin
        state       <= S_IDLE;
        ACTIVE_UNIT <= '0;
        wait_cnt    <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              if (|type_onehot) begin
                ACTIVE_UNIT <= type_onehot;
                state       <= S_ISSUE;
              end else begin
                ILLEGAL <= 1'b1;
              end
            end
          end
          S_ISSUE: begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
          S_WAIT: begin
            // Done is checked first so it wins over a coincident timeout.
            if (done_hit) begin
              COMPLETE    <= 1'b1;
              ACTIVE_UNIT <= '0;
              state       <= S_IDLE;
            end else if (timeout_hit) begin
              TIMEOUT     <= 1'b1;
              ACTIVE_UNIT <= '0;
              state       <= S_IDLE;
            end else if (wait_cnt != '1) begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
